// File: rtl/sum_result_fifo.sv
// sum_result_fifo: first-word-fall-through FIFO behind the adder.
// The adder pushes sums with a bare valid pulse and never stalls. The consumer
// drains them over a valid/ready handshake. When a sum arrives on a full FIFO
// and nothing leaves in the same cycle, that sum is dropped and counted.
module sum_result_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        drop_cnt,
  input  logic                    clr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Storage is data only and is deliberately left out of reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;

  logic pop;
  logic push;
  logic drop;

  // A pop needs a presented word, so an empty FIFO never pops even with
  // out_ready high. A full FIFO still accepts a push when a pop frees a slot.
  assign pop  = !empty_q && out_ready;
  assign push = in_valid && (!full_q || pop);
  assign drop = in_valid && full_q && !pop;

  // Outputs come purely from registered state; nothing from in_* reaches them
  // combinationally. The zero mux keeps out_data clean while empty.
  assign out_valid = !empty_q;
  assign out_data  = empty_q ? '0 : mem[rd_ptr];
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign drop_cnt  = drop_q;

  // Next occupancy from the push/pop pair.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Next drop count: the clear applies first, then a same-edge drop counts.
  always_comb begin
    drop_d = clr_drop ? '0 : drop_q;
    if (drop) begin
      drop_d = sat_inc(drop_d);
    end
  end

  // Write port: the word lands at wr_ptr on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Occupancy and its flags move together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

endmodule
